// File: rtl/smc_stream.sv
// Six-beat transistor packet engine: per-beat gm/current value, top/bottom-3 select, weighted result.
// Optional build macro SMC_STREAM_ABORT_EN: an in_valid gap mid-packet aborts instead of stalling.
module smc_stream (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [2:0] W,
  input  logic [2:0] V_GS,
  input  logic [2:0] V_DS,
  output logic       out_valid,
  output logic [9:0] out_n
);

  localparam int DATA_W = 8;
  localparam int QUOT_W = 7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [1:0]                   mode_q, mode_d;
  logic [5:0][DATA_W-1:0]       val_q, val_d;
  logic [2:0][QUOT_W-1:0]       a_q, a_d;

  logic [DATA_W-1:0]            srt [6];
  logic [DATA_W-1:0]            n0, n1, n2;

  // All operands are non-negative and the worst case (252) fits the 8-bit context.
  function automatic logic [DATA_W-1:0] beat_val(input logic cur, input logic [2:0] w,
                                                 input logic [2:0] vgs, input logic [2:0] vds);
    logic [DATA_W-1:0] g8, d8, w8, r;
    g8 = (vgs == 3'd0) ? '0 : {5'd0, vgs - 3'd1};
    d8 = {5'd0, vds};
    w8 = {5'd0, w};
    if (!cur) begin
      r = (g8 > d8) ? ((d8 << 1) * w8) : ((g8 << 1) * w8);
    end else begin
      r = (g8 > d8) ? (((g8 << 1) - d8) * d8 * w8) : (g8 * g8 * w8);
    end
    return r;
  endfunction

  function automatic logic [QUOT_W-1:0] div3(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] q;
    q = x / 8'd3;
    return q[QUOT_W-1:0];
  endfunction

  function automatic logic [9:0] result(input logic cur, input logic [QUOT_W-1:0] q0,
                                        input logic [QUOT_W-1:0] q1, input logic [QUOT_W-1:0] q2);
    logic [9:0] e0, e1, e2;
    e0 = {3'd0, q0};
    e1 = {3'd0, q1};
    e2 = {3'd0, q2};
    return cur ? (10'd3 * e0 + 10'd4 * e1 + 10'd5 * e2) : (e0 + e1 + e2);
  endfunction

  // Ascending bubble sort of the six stored values.
  always_comb begin
    logic [DATA_W-1:0] tmp;
    tmp = '0;
    for (int i = 0; i < 6; i++) srt[i] = val_q[i];
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        if (srt[j] > srt[j+1]) begin
          tmp      = srt[j];
          srt[j]   = srt[j+1];
          srt[j+1] = tmp;
        end
      end
    end
  end

  always_comb begin
    if (mode_q[1]) begin
      n0 = srt[5];
      n1 = srt[4];
      n2 = srt[3];
    end else begin
      n0 = srt[2];
      n1 = srt[1];
      n2 = srt[0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    val_d   = val_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          val_d[0] = beat_val(mode[0], W, V_GS, V_DS);
          mode_d   = mode;
          cnt_d    = 3'd1;
          state_d  = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          val_d[cnt_q] = beat_val(mode_q[0], W, V_GS, V_DS);
          if (cnt_q == 3'd5) begin
            cnt_d   = 3'd0;
            state_d = S_CALC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
`ifdef SMC_STREAM_ABORT_EN
          cnt_d   = 3'd0;
          state_d = S_IDLE;
`else
          state_d = S_ACC;
`endif
        end
      end
      S_CALC: begin
        a_d[0]  = div3(n0);
        a_d[1]  = div3(n1);
        a_d[2]  = div3(n2);
        state_d = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      val_q   <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      a_q     <= a_d;
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign out_n     = out_valid ? result(mode_q[0], a_q[0], a_q[1], a_q[2]) : 10'd0;

endmodule
